// File: rtl/mcs51_port.sv
// MCS-51 style 8-bit quasi-bidirectional port: SFR latch, pin synchroniser, 0->1 strong pull-up.
// Optional falling-edge flags are built when MCS51_PORT_EDGE_EN is defined.
module mcs51_port #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         PULLUP_CYCLES = 2,
  parameter logic [7:0] RESET_VAL     = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sfr_we,
  input  logic [7:0] sfr_wdata,
  input  logic       bit_we,
  input  logic [2:0] bit_sel,
  input  logic       bit_wdata,
  input  logic       rmw,
  output logic [7:0] rdata,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_out,
`ifdef MCS51_PORT_EDGE_EN
  output logic [7:0] edge_flag,
  input  logic [7:0] edge_clr,
`endif
  output logic [7:0] pin_oe
);

  logic [7:0] r_latch;
  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] w_latch_nxt;
  logic [7:0] w_pin_sync;
  logic [7:0] w_oe;

  // Next latch value: byte write first, bit write overlays the selected bit.
  always_comb begin
    w_latch_nxt = r_latch;
    if (sfr_we) begin
      w_latch_nxt = sfr_wdata;
    end else begin
      w_latch_nxt = r_latch;
    end
    if (bit_we) begin
      w_latch_nxt[bit_sel] = bit_wdata;
    end else begin
      w_latch_nxt[bit_sel] = w_latch_nxt[bit_sel];
    end
  end

  // Output latch register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch <= RESET_VAL;
    end else begin
      r_latch <= w_latch_nxt;
    end
  end

  // Pin synchroniser chain, preset high so an idle pull-up reads as 1 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 8'hFF;
    end else begin
      r_sync[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_pin_sync = r_sync[SYNC_STAGES-1];

  generate
    if (PULLUP_CYCLES > 0) begin : g_boost
      localparam int BW = $clog2(PULLUP_CYCLES + 1);
      localparam logic [BW-1:0] BOOST_LOAD = BW'(PULLUP_CYCLES);
      logic [BW-1:0] r_boost [8];
      logic [7:0]    w_boost_on;

      // Per-bit boost counter: load on latch 0->1, clear on a 0 write, else count down.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < 8; i++) r_boost[i] <= {BW{1'b0}};
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (!r_latch[i] && w_latch_nxt[i]) begin
              r_boost[i] <= BOOST_LOAD;
            end else if (!w_latch_nxt[i]) begin
              r_boost[i] <= {BW{1'b0}};
            end else if (r_boost[i] != {BW{1'b0}}) begin
              r_boost[i] <= r_boost[i] - BW'(1);
            end else begin
              r_boost[i] <= r_boost[i];
            end
          end
        end
      end

      // Strong drive while a counter is running.
      always_comb begin
        w_boost_on = 8'h00;
        for (int i = 0; i < 8; i++) w_boost_on[i] = (r_boost[i] != {BW{1'b0}});
      end

      assign w_oe = ~r_latch | w_boost_on;
    end else begin : g_no_boost
      assign w_oe = ~r_latch;
    end
  endgenerate

`ifdef MCS51_PORT_EDGE_EN
  logic [7:0] r_prev;
  logic [7:0] r_edge_flag;
  logic [7:0] w_fall;

  assign w_fall = r_prev & ~w_pin_sync;

  // Sticky falling-edge flags; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev      <= 8'hFF;
      r_edge_flag <= 8'h00;
    end else begin
      r_prev      <= w_pin_sync;
      r_edge_flag <= (r_edge_flag & ~edge_clr) | w_fall;
    end
  end

  assign edge_flag = r_edge_flag;
`endif

  assign rdata   = rmw ? r_latch : w_pin_sync;
  assign pin_out = r_latch;
  assign pin_oe  = w_oe;

endmodule
